// File: rtl/hilo_sched_pkg.sv
// ============================================================================
// Module : hilo_sched_pkg
// Brief  : Shared HILOOp codes, default latencies and FSM encodings for the
//          HI/LO sequencer. Optional feature macro: MADD_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package hilo_sched_pkg;

    // Must match the decoder's HILOOp encoding
    localparam logic [4:0] HILO_NONE  = 5'd0;
    localparam logic [4:0] HILO_MULT  = 5'd1;
    localparam logic [4:0] HILO_MULTU = 5'd2;
    localparam logic [4:0] HILO_DIV   = 5'd3;
    localparam logic [4:0] HILO_DIVU  = 5'd4;
    localparam logic [4:0] HILO_MFHI  = 5'd5;
    localparam logic [4:0] HILO_MFLO  = 5'd6;
    localparam logic [4:0] HILO_MTHI  = 5'd7;
    localparam logic [4:0] HILO_MTLO  = 5'd8;
    localparam logic [4:0] HILO_MADD  = 5'd9;

    localparam int DEF_MULT_CYCLES = 5;
    localparam int DEF_DIV_CYCLES  = 10;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    typedef enum logic [0:0] {
        S_IDLE = ST_IDLE,
        S_BUSY = ST_BUSY
    } state_t;

    function automatic logic is_launch_op(input logic [4:0] op);
        logic r;
        r = (op == HILO_MULT) || (op == HILO_MULTU) ||
            (op == HILO_DIV)  || (op == HILO_DIVU);
`ifdef MADD_EN
        r = r || (op == HILO_MADD);
`endif
        return r;
    endfunction

    function automatic logic is_div_op(input logic [4:0] op);
        return (op == HILO_DIV) || (op == HILO_DIVU);
    endfunction

endpackage

`default_nettype wire

// File: rtl/hilo_calc.sv
// ============================================================================
// Module : hilo_calc
// Brief  : Combinational 64-bit result generator for mult/multu/div/divu
//          (and madd when MADD_EN is defined).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module hilo_calc
    import hilo_sched_pkg::*;
(
    input  logic [4:0]  op,
    input  logic [31:0] rs,
    input  logic [31:0] rt,
    input  logic [31:0] hi,
    input  logic [31:0] lo,
    output logic [63:0] result,
    output logic        div_by_zero
);

    logic [63:0] w_sprod;
    logic [63:0] w_uprod;
    logic [31:0] w_udiv;
    logic [31:0] w_uq;
    logic [31:0] w_ur;
    logic [31:0] w_abs_rs;
    logic [31:0] w_abs_rt;
    logic [31:0] w_sdiv;
    logic [31:0] w_sq_mag;
    logic [31:0] w_sr_mag;
    logic [31:0] w_sq;
    logic [31:0] w_sr;

    // Low 64 bits of sign-extended operands give the signed product
    assign w_sprod = {{32{rs[31]}}, rs} * {{32{rt[31]}}, rt};
    assign w_uprod = {32'd0, rs} * {32'd0, rt};

    // Divisor forced to 1 on zero so the dividers never see a zero operand
    assign w_udiv = (rt == 32'd0) ? 32'd1 : rt;
    assign w_uq   = rs / w_udiv;
    assign w_ur   = rs % w_udiv;

    // Signed divide on magnitudes; handles 0x80000000 / -1 without overflow
    assign w_abs_rs = rs[31] ? (32'd0 - rs) : rs;
    assign w_abs_rt = rt[31] ? (32'd0 - rt) : rt;
    assign w_sdiv   = (w_abs_rt == 32'd0) ? 32'd1 : w_abs_rt;
    assign w_sq_mag = w_abs_rs / w_sdiv;
    assign w_sr_mag = w_abs_rs % w_sdiv;
    assign w_sq     = (rs[31] ^ rt[31]) ? (32'd0 - w_sq_mag) : w_sq_mag;
    assign w_sr     = rs[31] ? (32'd0 - w_sr_mag) : w_sr_mag;

    assign div_by_zero = is_div_op(op) && (rt == 32'd0);

`ifndef MADD_EN
    logic w_unused_hilo;
    assign w_unused_hilo = ^{hi, lo};
`endif

    always_comb begin
        result = 64'd0;
        case (op)
            HILO_MULT:  result = w_sprod;
            HILO_MULTU: result = w_uprod;
            HILO_DIV:   result = {w_sr, w_sq};
            HILO_DIVU:  result = {w_ur, w_uq};
`ifdef MADD_EN
            HILO_MADD:  result = {hi, lo} + w_sprod;
`endif
            default:    result = 64'd0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/hilo_sched.sv
// ============================================================================
// Module : hilo_sched
// Brief  : HI/LO multiply/divide sequencer for the E stage: launch, fixed
//          latency countdown, HI/LO commit, mf/mt service and D-stage stall.
//          Optional feature macro: MADD_EN (enables op 9, madd).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module hilo_sched
    import hilo_sched_pkg::*;
#(
    parameter int MULT_CYCLES = DEF_MULT_CYCLES,
    parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  E_HILOOp,
    input  logic [31:0] E_RS,
    input  logic [31:0] E_RT,
    input  logic        req,
    input  logic        D_isHILO,
    output logic        busy,
    output logic        start,
    output logic        D_stall,
    output logic [31:0] HILO_out,
    output logic [31:0] HI_q,
    output logic [31:0] LO_q
);

    localparam logic [3:0] c_mult_cnt = 4'(MULT_CYCLES);
    localparam logic [3:0] c_div_cnt  = 4'(DIV_CYCLES);

    state_t      r_state;
    logic [3:0]  r_count;
    logic [63:0] r_pending;
    logic        r_pend_dz;

    logic [63:0] w_result;
    logic        w_dz;
    logic        w_mt_ok;

    hilo_calc u_calc (
        .op          (E_HILOOp),
        .rs          (E_RS),
        .rt          (E_RT),
        .hi          (HI_q),
        .lo          (LO_q),
        .result      (w_result),
        .div_by_zero (w_dz)
    );

    assign start   = is_launch_op(E_HILOOp) && !req && !busy;
    assign w_mt_ok = !req && !busy;
    assign D_stall = D_isHILO && (start || busy);

    always_comb begin
        HILO_out = 32'd0;
        if (E_HILOOp == HILO_MFHI)
            HILO_out = HI_q;
        else if (E_HILOOp == HILO_MFLO)
            HILO_out = LO_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            busy      <= 1'b0;
            r_count   <= 4'd0;
            r_pending <= 64'd0;
            r_pend_dz <= 1'b0;
            HI_q      <= 32'd0;
            LO_q      <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_pending <= w_result;
                        r_pend_dz <= w_dz;
                        r_count   <= is_div_op(E_HILOOp) ? c_div_cnt : c_mult_cnt;
                        busy      <= 1'b1;
                        r_state   <= S_BUSY;
                    end else if (w_mt_ok && (E_HILOOp == HILO_MTHI)) begin
                        HI_q <= E_RS;
                    end else if (w_mt_ok && (E_HILOOp == HILO_MTLO)) begin
                        LO_q <= E_RS;
                    end
                end
                S_BUSY: begin
                    // req is ignored here: the running op is older than the flushed one
                    if (r_count == 4'd1) begin
                        if (!r_pend_dz) begin
                            HI_q <= r_pending[63:32];
                            LO_q <= r_pending[31:0];
                        end
                        r_count <= 4'd0;
                        busy    <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_count <= r_count - 4'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_hilo_sched.sv
// ============================================================================
// Module : tb_hilo_sched
// Brief  : Scoreboard bench for hilo_sched; directed vectors with expected
//          values queued per cycle and checked by an independent monitor.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_hilo_sched;
    import hilo_sched_pkg::*;

    localparam int c_sel_busy  = 0;
    localparam int c_sel_start = 1;
    localparam int c_sel_stall = 2;
    localparam int c_sel_out   = 3;
    localparam int c_sel_hi    = 4;
    localparam int c_sel_lo    = 5;

    typedef struct {
        int          cyc;
        int          sel;
        logic [31:0] val;
        string       name;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  E_HILOOp;
    logic [31:0] E_RS;
    logic [31:0] E_RT;
    logic        req;
    logic        D_isHILO;
    logic        busy;
    logic        start;
    logic        D_stall;
    logic [31:0] HILO_out;
    logic [31:0] HI_q;
    logic [31:0] LO_q;

    exp_t sb[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    hilo_sched dut (
        .clk      (clk),
        .reset    (reset),
        .E_HILOOp (E_HILOOp),
        .E_RS     (E_RS),
        .E_RT     (E_RT),
        .req      (req),
        .D_isHILO (D_isHILO),
        .busy     (busy),
        .start    (start),
        .D_stall  (D_stall),
        .HILO_out (HILO_out),
        .HI_q     (HI_q),
        .LO_q     (LO_q)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] observed(input int sel);
        case (sel)
            c_sel_busy:  return {31'd0, busy};
            c_sel_start: return {31'd0, start};
            c_sel_stall: return {31'd0, D_stall};
            c_sel_out:   return HILO_out;
            c_sel_hi:    return HI_q;
            default:     return LO_q;
        endcase
    endfunction

    // Monitor: compare every expectation due in the current cycle
    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == cyc) begin
                checks++;
                if (observed(sb[i].sel) !== sb[i].val) begin
                    errors++;
                    $display("FAIL %s cycle %0d: got 0x%08h expected 0x%08h",
                             sb[i].name, cyc, observed(sb[i].sel), sb[i].val);
                end
                sb.delete(i);
            end
        end
    end

    task automatic expect_at(input int dc, input int sel, input logic [31:0] val,
                             input string name);
        exp_t e;
        e.cyc  = cyc + dc;
        e.sel  = sel;
        e.val  = val;
        e.name = name;
        sb.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic drive(input logic [4:0] op, input logic [31:0] rs,
                         input logic [31:0] rt, input logic rq);
        E_HILOOp = op;
        E_RS     = rs;
        E_RT     = rt;
        req      = rq;
    endtask

    initial begin
        reset    = 1'b1;
        D_isHILO = 1'b0;
        drive(HILO_NONE, 32'd0, 32'd0, 1'b0);
        step();
        step();
        reset = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL direct_reset_busy: got %b expected 0", busy);
        end
        checks++;
        if (HI_q !== 32'd0) begin
            errors++;
            $display("FAIL direct_reset_hi: got 0x%08h expected 0x00000000", HI_q);
        end
        expect_at(0, c_sel_busy, 32'd0, "reset_busy");
        expect_at(0, c_sel_hi,   32'd0, "reset_hi");
        expect_at(0, c_sel_lo,   32'd0, "reset_lo");
        expect_at(0, c_sel_out,  32'd0, "reset_out");

        // mult -1 * 2
        drive(HILO_MULT, 32'hFFFF_FFFF, 32'h2, 1'b0);
        expect_at(0, c_sel_start, 32'd1, "mult_start");
        for (int k = 1; k <= 5; k++) expect_at(k, c_sel_busy, 32'd1, "mult_busy");
        expect_at(5, c_sel_hi,   32'd0, "mult_hi_early");
        expect_at(6, c_sel_busy, 32'd0, "mult_done");
        expect_at(6, c_sel_hi,   32'hFFFF_FFFF, "mult_hi");
        expect_at(6, c_sel_lo,   32'hFFFF_FFFE, "mult_lo");
        step();
        drive(HILO_NONE, 32'd0, 32'd0, 1'b0);
        idle(6);

        // multu with D-stage stall observation
        D_isHILO = 1'b1;
        drive(HILO_MULTU, 32'hFFFF_FFFF, 32'h2, 1'b0);
        expect_at(0, c_sel_start, 32'd1, "multu_start");
        expect_at(0, c_sel_stall, 32'd1, "stall_on_start");
        step();
        drive(HILO_NONE, 32'd0, 32'd0, 1'b0);
        expect_at(0, c_sel_busy,  32'd1, "multu_busy");
        expect_at(0, c_sel_stall, 32'd1, "stall_busy");
        step();
        D_isHILO = 1'b0;
        expect_at(0, c_sel_stall, 32'd0, "stall_no_hilo");
        step();
        D_isHILO = 1'b1;
        expect_at(0, c_sel_stall, 32'd1, "stall_busy2");
        idle(3);
        expect_at(0, c_sel_stall, 32'd0, "stall_free");
        expect_at(0, c_sel_busy,  32'd0, "multu_done");
        expect_at(0, c_sel_hi,    32'h1, "multu_hi");
        expect_at(0, c_sel_lo,    32'hFFFF_FFFE, "multu_lo");
        step();
        D_isHILO = 1'b0;

        // div -7 / 2
        drive(HILO_DIV, 32'hFFFF_FFF9, 32'h2, 1'b0);
        expect_at(0,  c_sel_start, 32'd1, "div_start");
        expect_at(10, c_sel_busy,  32'd1, "div_busy10");
        expect_at(10, c_sel_lo,    32'hFFFF_FFFE, "div_lo_early");
        expect_at(11, c_sel_busy,  32'd0, "div_done");
        expect_at(11, c_sel_hi,    32'hFFFF_FFFF, "div_hi");
        expect_at(11, c_sel_lo,    32'hFFFF_FFFD, "div_lo");
        step();
        drive(HILO_NONE, 32'd0, 32'd0, 1'b0);
        idle(11);

        // divu by zero: full latency, HI/LO unchanged
        drive(HILO_DIVU, 32'h7, 32'h0, 1'b0);
        expect_at(0,  c_sel_start, 32'd1, "divz_start");
        expect_at(1,  c_sel_busy,  32'd1, "divz_busy1");
        expect_at(10, c_sel_busy,  32'd1, "divz_busy10");
        expect_at(11, c_sel_busy,  32'd0, "divz_done");
        expect_at(11, c_sel_hi,    32'hFFFF_FFFF, "divz_hi");
        expect_at(11, c_sel_lo,    32'hFFFF_FFFD, "divz_lo");
        step();
        drive(HILO_NONE, 32'd0, 32'd0, 1'b0);
        idle(10);

        // back-to-back launch: 0x80000000 / -1
        drive(HILO_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        expect_at(0,  c_sel_start, 32'd1, "b2b_start");
        expect_at(11, c_sel_hi,    32'h0, "ovf_hi");
        expect_at(11, c_sel_lo,    32'h8000_0000, "ovf_lo");
        step();
        drive(HILO_NONE, 32'd0, 32'd0, 1'b0);
        idle(11);

        // mult flushed by req
        drive(HILO_MULT, 32'h5, 32'h5, 1'b1);
        expect_at(0, c_sel_start, 32'd0, "req_start");
        expect_at(1, c_sel_busy,  32'd0, "req_busy");
        expect_at(1, c_sel_hi,    32'h0, "req_hi");
        expect_at(7, c_sel_lo,    32'h8000_0000, "req_lo");
        step();
        drive(HILO_NONE, 32'd0, 32'd0, 1'b0);
        idle(7);

        // mthi flushed by req
        drive(HILO_MTHI, 32'h1234, 32'h0, 1'b1);
        expect_at(1, c_sel_hi, 32'h0, "mthi_req");
        step();

        // mthi then mf reads
        drive(HILO_MTHI, 32'hAAAA_5555, 32'h0, 1'b0);
        expect_at(1, c_sel_hi, 32'hAAAA_5555, "mthi_hi");
        step();
        checks++;
        if (HI_q !== 32'hAAAA_5555) begin
            errors++;
            $display("FAIL direct_mthi_hi: got 0x%08h expected 0xaaaa5555", HI_q);
        end
        drive(HILO_MFHI, 32'h0, 32'h0, 1'b0);
        expect_at(0, c_sel_out, 32'hAAAA_5555, "mfhi_out");
        step();
        drive(HILO_MFLO, 32'h0, 32'h0, 1'b0);
        expect_at(0, c_sel_out, 32'h8000_0000, "mflo_out");
        step();
        drive(HILO_NONE, 32'd0, 32'd0, 1'b0);
        expect_at(0, c_sel_out, 32'h0, "none_out");
        step();

        // mtlo while busy is ignored
        drive(HILO_MULT, 32'h3, 32'h4, 1'b0);
        expect_at(6, c_sel_hi, 32'h0, "mul34_hi");
        expect_at(6, c_sel_lo, 32'hC, "mul34_lo");
        step();
        drive(HILO_NONE, 32'd0, 32'd0, 1'b0);
        step();
        drive(HILO_MTLO, 32'hDEAD, 32'h0, 1'b0);
        expect_at(1, c_sel_lo, 32'h8000_0000, "mtlo_busy");
        step();
        drive(HILO_NONE, 32'd0, 32'd0, 1'b0);
        idle(4);

        // reset in busy cycle 3 of a div abandons the result
        drive(HILO_DIV, 32'd100, 32'd7, 1'b0);
        expect_at(0, c_sel_start, 32'd1, "rdiv_start");
        step();
        drive(HILO_NONE, 32'd0, 32'd0, 1'b0);
        step();
        step();
        reset = 1'b1;
        expect_at(1, c_sel_busy, 32'd0, "rst_busy");
        expect_at(1, c_sel_hi,   32'd0, "rst_hi");
        expect_at(1, c_sel_lo,   32'd0, "rst_lo");
        expect_at(9, c_sel_hi,   32'd0, "rst_hi_late");
        expect_at(9, c_sel_lo,   32'd0, "rst_lo_late");
        expect_at(9, c_sel_busy, 32'd0, "rst_busy_late");
        step();
        reset = 1'b0;
        idle(10);

`ifdef MADD_EN
        drive(HILO_MTLO, 32'hFFFF_FFFF, 32'h0, 1'b0);
        step();
        drive(HILO_MTHI, 32'h0, 32'h0, 1'b0);
        step();
        drive(HILO_MADD, 32'h1, 32'h1, 1'b0);
        expect_at(0, c_sel_start, 32'd1, "madd_start");
        expect_at(5, c_sel_busy,  32'd1, "madd_busy");
        expect_at(6, c_sel_busy,  32'd0, "madd_done");
        expect_at(6, c_sel_hi,    32'h1, "madd_hi");
        expect_at(6, c_sel_lo,    32'h0, "madd_lo");
        step();
        drive(HILO_NONE, 32'd0, 32'd0, 1'b0);
        idle(6);
`else
        D_isHILO = 1'b1;
        drive(HILO_MADD, 32'h1, 32'h1, 1'b0);
        expect_at(0, c_sel_start, 32'd0, "op9_start");
        expect_at(0, c_sel_out,   32'd0, "op9_out");
        expect_at(0, c_sel_stall, 32'd0, "op9_stall");
        expect_at(1, c_sel_busy,  32'd0, "op9_busy");
        expect_at(1, c_sel_hi,    32'd0, "op9_hi");
        step();
        drive(HILO_NONE, 32'd0, 32'd0, 1'b0);
        D_isHILO = 1'b0;
        step();
`endif

        idle(3);
        while (sb.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL %s never checked: due cycle %0d, now %0d",
                     sb[0].name, sb[0].cyc, cyc);
            sb.delete(0);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
